// File: rtl/spi_slave_ctrl.sv
// rtl/spi_slave_ctrl.sv - SPI slave with one-word TX holding register and RX word output
// Optional LSB-first bit order: define SPI_SLAVE_LSB_FIRST_EN.

module spi_slave_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int CPOL       = 0,
  parameter int CPHA       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_underrun
);

  localparam int            CW       = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_SHIFT = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic                  r_sclk_s1, r_sclk_s2, r_sclk_s3;
  logic                  r_cs_s1, r_cs_s2;
  logic                  r_mosi_s1, r_mosi_s2;
  logic [1:0]            r_warm;
  logic [CW-1:0]         r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_tx_shift;
  logic [DATA_WIDTH-1:0] r_rx_shift;
  logic [DATA_WIDTH-1:0] r_hold;
  logic                  r_hold_full;
  logic                  r_need_load;

  logic                  w_rise, w_fall, w_lead, w_trail;
  logic                  w_in_shift, w_sample, w_shift, w_enter, w_load, w_last, w_accept;
  logic                  w_tx_bit;
  logic [DATA_WIDTH-1:0] w_tx_shifted;
  logic [DATA_WIDTH-1:0] w_rx_next;

  // r_warm masks the reset value of the cs_n synchronizer so a cs_n held low
  // through reset is never mistaken for an idle-high observation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_s1 <= 1'b0;
      r_sclk_s2 <= 1'b0;
      r_sclk_s3 <= 1'b0;
      r_cs_s1   <= 1'b1;
      r_cs_s2   <= 1'b1;
      r_mosi_s1 <= 1'b0;
      r_mosi_s2 <= 1'b0;
      r_warm    <= 2'b00;
    end else begin
      r_sclk_s1 <= sclk;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_s3 <= r_sclk_s2;
      r_cs_s1   <= cs_n;
      r_cs_s2   <= r_cs_s1;
      r_mosi_s1 <= mosi;
      r_mosi_s2 <= r_mosi_s1;
      r_warm    <= {r_warm[0], 1'b1};
    end
  end

  assign w_rise  = r_sclk_s2 & ~r_sclk_s3;
  assign w_fall  = ~r_sclk_s2 & r_sclk_s3;
  assign w_lead  = (CPOL != 0) ? w_fall : w_rise;
  assign w_trail = (CPOL != 0) ? w_rise : w_fall;

  assign w_in_shift = (r_state == S_SHIFT) && !r_cs_s2;
  assign w_enter    = (r_state == S_ARMED) && !r_cs_s2;
  assign w_sample   = w_in_shift && ((CPHA != 0) ? w_trail : w_lead);
  assign w_shift    = w_in_shift && ((CPHA != 0) ? w_lead : w_trail);
  assign w_last     = w_sample && (r_bit_cnt == LAST_BIT);
  // Reload is deferred to the first shift edge of the next word so a frame
  // that ends on a word boundary does not consume the holding register in CPHA=1.
  assign w_load     = w_enter || (w_shift && r_need_load);
  assign w_accept   = tx_valid && !r_hold_full;

`ifdef SPI_SLAVE_LSB_FIRST_EN
  assign w_tx_bit     = r_tx_shift[0];
  assign w_tx_shifted = {1'b1, r_tx_shift[DATA_WIDTH-1:1]};
  assign w_rx_next    = {r_mosi_s2, r_rx_shift[DATA_WIDTH-1:1]};
`else
  assign w_tx_bit     = r_tx_shift[DATA_WIDTH-1];
  assign w_tx_shifted = {r_tx_shift[DATA_WIDTH-2:0], 1'b1};
  assign w_rx_next    = {r_rx_shift[DATA_WIDTH-2:0], r_mosi_s2};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (r_warm[1] && r_cs_s2) w_next = S_ARMED;
      S_ARMED: if (!r_cs_s2) w_next = S_SHIFT;
      S_SHIFT: if (r_cs_s2) w_next = S_ARMED;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_cnt   <= '0;
      r_tx_shift  <= '0;
      r_rx_shift  <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_need_load <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;

      if (w_load) begin
        r_tx_shift  <= r_hold_full ? r_hold : '1;
        tx_underrun <= !r_hold_full;
      end else if (w_shift && (r_bit_cnt != '0)) begin
        r_tx_shift <= w_tx_shifted;
      end

      // A reload in the same cycle sees the old contents; the new word lands after it.
      if (w_accept) begin
        r_hold      <= tx_data;
        r_hold_full <= 1'b1;
      end else if (w_load) begin
        r_hold_full <= 1'b0;
      end

      if (w_enter) begin
        r_need_load <= 1'b0;
      end else if (w_last) begin
        r_need_load <= 1'b1;
      end else if (w_load) begin
        r_need_load <= 1'b0;
      end

      if (!w_in_shift) begin
        r_bit_cnt <= '0;
      end else if (w_sample) begin
        r_rx_shift <= w_rx_next;
        if (w_last) begin
          r_bit_cnt <= '0;
          rx_data   <= w_rx_next;
          rx_valid  <= 1'b1;
        end else begin
          r_bit_cnt <= r_bit_cnt + CW'(1);
        end
      end
    end
  end

  assign tx_ready = !r_hold_full;
  assign miso_oe  = (r_state == S_SHIFT);
  assign miso     = miso_oe ? w_tx_bit : 1'b1;

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// tb/tb_spi_slave_ctrl.sv - bench for spi_slave_ctrl in mode 0 and mode 3 against a word-level model
// Honours SPI_SLAVE_LSB_FIRST_EN for bit order.

module tb_spi_slave_ctrl;
  localparam int DW = 8;
  localparam int H  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          sclk[2], cs_n[2], mosi[2], miso[2], miso_oe[2];
  logic          tx_valid[2], tx_ready[2], rx_valid[2], tx_underrun[2];
  logic [DW-1:0] tx_data[2], rx_data[2];

  spi_slave_ctrl #(.DATA_WIDTH(DW), .CPOL(0), .CPHA(0)) u_m0 (
    .clk(clk), .rst(rst), .sclk(sclk[0]), .cs_n(cs_n[0]), .mosi(mosi[0]),
    .miso(miso[0]), .miso_oe(miso_oe[0]), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .rx_data(rx_data[0]), .rx_valid(rx_valid[0]),
    .tx_underrun(tx_underrun[0])
  );

  spi_slave_ctrl #(.DATA_WIDTH(DW), .CPOL(1), .CPHA(1)) u_m3 (
    .clk(clk), .rst(rst), .sclk(sclk[1]), .cs_n(cs_n[1]), .mosi(mosi[1]),
    .miso(miso[1]), .miso_oe(miso_oe[1]), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .rx_data(rx_data[1]), .rx_valid(rx_valid[1]),
    .tx_underrun(tx_underrun[1])
  );

  int errors = 0;
  int checks = 0;
  int rxcnt[2] = '{0, 0};
  int urcnt[2] = '{0, 0};

  logic [DW-1:0] mw[4], sw[4], rxd[4];
  logic          early[4], on[4];
  logic          oe_ok;

  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (rx_valid[m] === 1'b1) rxcnt[m]++;
      if (tx_underrun[m] === 1'b1) urcnt[m]++;
    end
  end

  function automatic int pos(input int i);
`ifdef SPI_SLAVE_LSB_FIRST_EN
    return i;
`else
    return DW - 1 - i;
`endif
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int m, input logic [DW-1:0] d);
    int t;
    t = 0;
    while (tx_ready[m] !== 1'b1 && t < 4000) begin
      tick(1);
      t++;
    end
    if (tx_ready[m] !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL push_timeout m%0d tx_ready=%b required 1", m, tx_ready[m]);
    end
    tx_data[m]  = d;
    tx_valid[m] = 1'b1;
    tick(1);
    tx_valid[m] = 1'b0;
  endtask

  // Master model: drives nbits of mw MSB/LSB-first, records what it samples on miso
  // and rx_valid/rx_data around the 3-cycle point after each word's last sampling edge.
  task automatic xfer(input int m, input int nbits);
    logic cpol, cpha;
    int   w, i;
    cpol  = (m == 1);
    cpha  = (m == 1);
    oe_ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sw[k] = '0; rxd[k] = '0; early[k] = 1'b0; on[k] = 1'b0;
    end
    if (!cpha) mosi[m] = mw[0][pos(0)];
    cs_n[m] = 1'b0;
    tick(H);
    for (int b = 0; b < nbits; b++) begin
      w = b / DW;
      i = b % DW;
      sclk[m] = ~cpol;
      if (cpha) begin
        mosi[m] = mw[w][pos(i)];
        tick(H);
        sclk[m] = cpol;
      end
      sw[w][pos(i)] = miso[m];
      oe_ok &= miso_oe[m];
      if (i == DW - 1) begin
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        early[w] = rx_valid[m];
        @(posedge clk);
        @(negedge clk);
        on[w]  = rx_valid[m];
        rxd[w] = rx_data[m];
        @(posedge clk);
        #1;
        tick(H - 4);
      end else begin
        tick(H);
      end
      if (!cpha) begin
        sclk[m] = cpol;
        if (b + 1 < nbits) mosi[m] = mw[(b + 1) / DW][pos((b + 1) % DW)];
        tick(H);
      end
    end
    tick(H);
    cs_n[m] = 1'b1;
    mosi[m] = 1'b0;
    tick(2 * H);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    for (int m = 0; m < 2; m++) begin
      checks++; if (tx_ready[m] !== 1'b1) begin errors++; $display("FAIL reset_tx_ready m%0d got %b want 1", m, tx_ready[m]); end
      checks++; if (rx_valid[m] !== 1'b0) begin errors++; $display("FAIL reset_rx_valid m%0d got %b want 0", m, rx_valid[m]); end
      checks++; if (tx_underrun[m] !== 1'b0) begin errors++; $display("FAIL reset_underrun m%0d got %b want 0", m, tx_underrun[m]); end
      checks++; if (miso_oe[m] !== 1'b0) begin errors++; $display("FAIL reset_miso_oe m%0d got %b want 0", m, miso_oe[m]); end
      checks++; if (miso[m] !== 1'b1) begin errors++; $display("FAIL reset_miso m%0d got %b want 1", m, miso[m]); end
      checks++; if (rx_data[m] !== '0) begin errors++; $display("FAIL reset_rx_data m%0d got %h want 00", m, rx_data[m]); end
    end
    rst = 1'b0;
    tick(4);
  endtask

  task automatic test_mode0_basic();
    int r0;
    r0 = rxcnt[0];
    push(0, 8'hA5);
    mw[0] = 8'h3C;
    xfer(0, 8);
    checks++; if (sw[0] !== 8'hA5) begin errors++; $display("FAIL m0_miso got %h want a5", sw[0]); end
    checks++; if (early[0] !== 1'b0) begin errors++; $display("FAIL m0_rx_valid_early got %b want 0", early[0]); end
    checks++; if (on[0] !== 1'b1) begin errors++; $display("FAIL m0_rx_valid_3clk got %b want 1", on[0]); end
    checks++; if (rxd[0] !== 8'h3C) begin errors++; $display("FAIL m0_rx_data got %h want 3c", rxd[0]); end
    checks++; if (rxcnt[0] - r0 !== 1) begin errors++; $display("FAIL m0_rx_pulses got %0d want 1", rxcnt[0] - r0); end
    checks++; if (oe_ok !== 1'b1) begin errors++; $display("FAIL m0_miso_oe_in_frame got %b want 1", oe_ok); end
    checks++; if (miso_oe[0] !== 1'b0 || miso[0] !== 1'b1) begin errors++; $display("FAIL m0_idle_out oe=%b miso=%b want 0 1", miso_oe[0], miso[0]); end
  endtask

  task automatic test_back_to_back();
    int r0, u0;
    r0 = rxcnt[1];
    u0 = urcnt[1];
    push(1, 8'hF0);
    mw[0] = 8'h12;
    mw[1] = 8'h34;
    fork
      xfer(1, 16);
      push(1, 8'h0F);
    join
    checks++; if (sw[0] !== 8'hF0) begin errors++; $display("FAIL b2b_miso0 got %h want f0", sw[0]); end
    checks++; if (sw[1] !== 8'h0F) begin errors++; $display("FAIL b2b_miso1 got %h want 0f", sw[1]); end
    checks++; if (rxd[0] !== 8'h12 || on[0] !== 1'b1) begin errors++; $display("FAIL b2b_rx0 got %h/%b want 12/1", rxd[0], on[0]); end
    checks++; if (rxd[1] !== 8'h34 || on[1] !== 1'b1) begin errors++; $display("FAIL b2b_rx1 got %h/%b want 34/1", rxd[1], on[1]); end
    checks++; if (rxcnt[1] - r0 !== 2) begin errors++; $display("FAIL b2b_rx_pulses got %0d want 2", rxcnt[1] - r0); end
    checks++; if (urcnt[1] - u0 !== 0) begin errors++; $display("FAIL b2b_underruns got %0d want 0", urcnt[1] - u0); end
  endtask

  task automatic test_underrun();
    int u0;
    u0 = urcnt[1];
    mw[0] = DW'($urandom);
    xfer(1, 8);
    checks++; if (sw[0] !== 8'hFF) begin errors++; $display("FAIL ur_miso got %h want ff", sw[0]); end
    checks++; if (urcnt[1] - u0 !== 1) begin errors++; $display("FAIL ur_pulses got %0d want 1", urcnt[1] - u0); end
    checks++; if (rxd[0] !== mw[0]) begin errors++; $display("FAIL ur_rx_data got %h want %h", rxd[0], mw[0]); end
  endtask

  task automatic test_abort();
    int r0;
    logic [DW-1:0] t2;
    t2 = DW'($urandom);
    r0 = rxcnt[0];
    push(0, DW'($urandom));
    mw[0] = DW'($urandom);
    fork
      xfer(0, 5);
      push(0, t2);
    join
    checks++; if (rxcnt[0] - r0 !== 0) begin errors++; $display("FAIL abort_rx_pulses got %0d want 0", rxcnt[0] - r0); end
    r0 = rxcnt[0];
    mw[0] = 8'h81;
    xfer(0, 8);
    checks++; if (rxd[0] !== 8'h81 || on[0] !== 1'b1) begin errors++; $display("FAIL abort_next_rx got %h/%b want 81/1", rxd[0], on[0]); end
    checks++; if (sw[0] !== t2) begin errors++; $display("FAIL abort_hold_kept got %h want %h", sw[0], t2); end
    checks++; if (rxcnt[0] - r0 !== 1) begin errors++; $display("FAIL abort_next_pulses got %0d want 1", rxcnt[0] - r0); end
  endtask

  task automatic test_reset_midframe();
    int r0;
    logic [DW-1:0] t;
    push(0, DW'($urandom));
    cs_n[0] = 1'b0;
    tick(H);
    for (int b = 0; b < 3; b++) begin
      sclk[0] = 1'b1; tick(H);
      sclk[0] = 1'b0; tick(H);
    end
    rst = 1'b1;
    tick(2);
    checks++; if (miso_oe[0] !== 1'b0 || miso[0] !== 1'b1) begin errors++; $display("FAIL rstmid_out oe=%b miso=%b want 0 1", miso_oe[0], miso[0]); end
    checks++; if (tx_ready[0] !== 1'b1 || rx_data[0] !== '0) begin errors++; $display("FAIL rstmid_regs ready=%b rx=%h want 1 00", tx_ready[0], rx_data[0]); end
    rst = 1'b0;
    r0 = rxcnt[0];
    for (int b = 0; b < DW; b++) begin
      mosi[0] = 1'($urandom);
      tick(H);
      sclk[0] = 1'b1; tick(H);
      sclk[0] = 1'b0;
      checks++; if (miso_oe[0] !== 1'b0) begin errors++; $display("FAIL rstmid_no_shift bit%0d oe=%b want 0", b, miso_oe[0]); end
    end
    tick(H);
    checks++; if (rxcnt[0] - r0 !== 0) begin errors++; $display("FAIL rstmid_rx_pulses got %0d want 0", rxcnt[0] - r0); end
    cs_n[0] = 1'b1;
    tick(2 * H);
    t = DW'($urandom);
    push(0, t);
    mw[0] = DW'($urandom);
    xfer(0, 8);
    checks++; if (rxd[0] !== mw[0] || sw[0] !== t) begin errors++; $display("FAIL rstmid_recover rx=%h miso=%h want %h %h", rxd[0], sw[0], mw[0], t); end
  endtask

  task automatic test_random();
    logic [DW-1:0] tw[4];
    int m, n;
    for (int it = 0; it < 6; it++) begin
      m = it % 2;
      n = $urandom_range(1, 3);
      for (int k = 0; k < 4; k++) begin
        tw[k] = DW'($urandom);
        mw[k] = DW'($urandom);
      end
      push(m, tw[0]);
      fork
        xfer(m, n * DW);
        for (int k = 1; k < n; k++) push(m, tw[k]);
      join
      for (int k = 0; k < n; k++) begin
        checks++; if (sw[k] !== tw[k]) begin errors++; $display("FAIL rand_miso it%0d w%0d got %h want %h", it, k, sw[k], tw[k]); end
        checks++; if (rxd[k] !== mw[k] || on[k] !== 1'b1) begin errors++; $display("FAIL rand_rx it%0d w%0d got %h/%b want %h/1", it, k, rxd[k], on[k], mw[k]); end
      end
    end
  endtask

`ifdef SPI_SLAVE_LSB_FIRST_EN
  task automatic test_lsb_first();
    push(0, 8'h01);
    mw[0] = 8'h80;
    xfer(0, 8);
    checks++; if (sw[0][0] !== 1'b1) begin errors++; $display("FAIL lsb_first_bit got %b want 1", sw[0][0]); end
    checks++; if (rxd[0] !== 8'h80) begin errors++; $display("FAIL lsb_rx_data got %h want 80", rxd[0]); end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    for (int m = 0; m < 2; m++) begin
      sclk[m]     = (m == 1);
      cs_n[m]     = 1'b1;
      mosi[m]     = 1'b0;
      tx_valid[m] = 1'b0;
      tx_data[m]  = '0;
    end
    test_reset();
    test_mode0_basic();
    test_back_to_back();
    test_underrun();
    test_abort();
    test_reset_midframe();
    test_random();
`ifdef SPI_SLAVE_LSB_FIRST_EN
    test_lsb_first();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_slave_ctrl.md
SPI_SLAVE_CTRL -- requirements
Module: spi_slave_ctrl

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 8, bits per SPI word (range 4..32).
REQ-002 SHALL provide parameter CPOL, default 0, idle level of sclk.
REQ-003 SHALL provide parameter CPHA, default 0: 0 = sample on leading edge; 1 = sample on trailing edge.
REQ-004 SHALL have port clk  input  1  system clock; the only clock in the block.
REQ-005 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-006 SHALL have port sclk  input  1  SPI serial clock from master, asynchronous to clk.
REQ-007 SHALL have port cs_n  input  1  active-low chip select from master, asynchronous.
REQ-008 SHALL have port mosi  input  1  master-out serial data, asynchronous.
REQ-009 SHALL have port miso  output  1  slave-out serial data.
REQ-010 SHALL have port miso_oe  output  1  miso drive enable, high only while selected.
REQ-011 SHALL have port tx_data  input  DATA_WIDTH  next word to transmit.
REQ-012 SHALL have port tx_valid  input  1  tx_data valid.
REQ-013 SHALL have port tx_ready  output  1  TX holding register empty.
REQ-014 SHALL have port rx_data  output  DATA_WIDTH  last received word.
REQ-015 SHALL have port rx_valid  output  1  one-cycle pulse, rx_data updated.
REQ-016 SHALL have port tx_underrun  output  1  one-cycle pulse, word sent without loaded data.

Function
REQ-017 SHALL pass sclk, cs_n and mosi through 2-flop synchronizers; edge detection uses the synchronized sclk; supported sclk frequency is at most clk/8.
REQ-018 SHALL implement states IDLE, ARMED, SHIFT: IDLE->ARMED when synced cs_n is high; ARMED->SHIFT on synced cs_n falling; SHIFT->ARMED on synced cs_n rising.
REQ-019 SHALL accept tx_data into a one-word holding register when tx_valid && tx_ready; tx_ready = holding register empty.
REQ-020 SHALL load the shift register from the holding register on SHIFT entry and after each completed word; if the holding register is empty, it loads all-ones and pulses tx_underrun for one cycle.
REQ-021 SHALL, for CPHA=0, present the first bit on miso at SHIFT entry, sample mosi on leading edges, and shift miso on trailing edges; for CPHA=1, shift on leading edges and sample on trailing edges.
REQ-022 SHALL transmit and receive MSB first (see REQ-033).
REQ-023 SHALL count sampled bits modulo DATA_WIDTH; on the DATA_WIDTH-th sample, rx_data is updated and rx_valid pulses in the same clk cycle, exactly 3 clk cycles after the sclk edge at the pin.
REQ-024 SHALL support back-to-back words within one cs_n frame with no gap sclk cycles.
REQ-025 SHALL, on cs_n rising mid-word, discard partial bits: no rx_valid, bit counter cleared, holding register contents kept.
REQ-026 SHALL drive miso_oe high only in SHIFT; miso equals 1 whenever miso_oe is low.
REQ-027 SHALL handle tx_valid coinciding with a reload: the reload takes the old holding value (or underrun), and the new word is accepted in the same cycle.
REQ-028 SHALL ignore sclk edges while in IDLE or ARMED.

Reset
REQ-029 SHALL, while rst is high, set state IDLE, tx_ready=1, rx_valid=0, tx_underrun=0, miso_oe=0, miso=1, rx_data=0, and clear the bit counter, shift and holding registers and synchronizers (cs_n synchronizer to 1).
REQ-030 SHALL, when rst is asserted mid-frame, abort the frame and not re-enter SHIFT until cs_n has been observed high (IDLE->ARMED).
REQ-031 SHALL have no asynchronous reset paths.

Configuration
REQ-032 SHALL recognise macro SPI_SLAVE_LSB_FIRST_EN.
REQ-033 SHALL, with SPI_SLAVE_LSB_FIRST_EN defined, shift and assemble LSB first on both miso and mosi; without it, MSB first.

Verification
REQ-034 SHALL cover mode 0, DATA_WIDTH=8: tx_data=0xA5 preloaded, master sends 0x3C -> miso bits 1,0,1,0,0,1,0,1; rx_data=0x3C; one rx_valid pulse 3 clk after the 8th rising sclk.
REQ-035 SHALL cover CPOL=1 CPHA=1: two back-to-back words 0x12, 0x34 with tx 0xF0, 0x0F loaded -> rx_valid twice with 0x12 then 0x34; miso carries 0xF0 then 0x0F.
REQ-036 SHALL cover empty holding register at frame start -> miso sends 0xFF and tx_underrun pulses once.
REQ-037 SHALL cover cs_n deasserted after 5 bits, followed by a full frame sending 0x81 -> no rx_valid for the aborted frame, then rx_data=0x81.
REQ-038 SHALL cover rst pulsed mid-frame with cs_n held low -> outputs at reset values, SHIFT not entered until cs_n rises and falls again.
REQ-039 SHALL cover a build with SPI_SLAVE_LSB_FIRST_EN defined: tx 0x01, master sends LSB-first 0x80 -> miso first bit 1; rx_data=0x80.
